// File: rtl/seq_sub_pkg.sv
// ----------------------------------------------------------------------------
// seq_sub_pkg
// Shared definitions for the multi-cycle subtractor seq_sub32:
//   - state_t    : controller states IDLE / CALC / DONE
//   - SLICE_W    : width of the shared ripple-borrow slice (16 bits)
//   - cnt_width(): slice-counter width for a given operand width, never below 1
// ----------------------------------------------------------------------------
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 16;

    // A single-slice configuration still needs a 1-bit counter so the
    // register and its comparisons stay well formed.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / SLICE_W);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : seq_sub_pkg

// File: rtl/sub16.sv
// ----------------------------------------------------------------------------
// sub16
// Purely combinational 16-bit ripple-borrow subtractor slice:
//   diff = a - b - bin (mod 2^16), bout = borrow out of the top bit.
// Ports:
//   a    [15:0] in  : minuend slice
//   b    [15:0] in  : subtrahend slice
//   bin         in  : borrow in from the lower slice
//   diff [15:0] out : slice difference
//   bout        out : borrow out to the next slice
// ----------------------------------------------------------------------------
module sub16
    import seq_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout
);

    // chain[i] is the borrow into bit i; chain[SLICE_W] leaves the slice.
    logic [SLICE_W:0] chain;

    assign chain[0] = bin;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fs
            assign diff[gi]      = a[gi] ^ b[gi] ^ chain[gi];
            assign chain[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & chain[gi]);
        end
    endgenerate

    assign bout = chain[SLICE_W];

endmodule : sub16

// File: rtl/seq_sub32.sv
// ----------------------------------------------------------------------------
// seq_sub32
// Multi-cycle two's-complement subtractor: diff = a - b, one 16-bit slice per
// clock through a single shared sub16. Operands are registered on accept and
// results are held until the consumer takes them.
// Ports:
//   clk                 in  : clock
//   rst                 in  : synchronous active-high reset
//   in_valid / in_ready     : operand handshake (in_ready high only in IDLE)
//   a, b     [WIDTH-1:0] in : minuend / subtrahend
//   out_valid / out_ready   : result handshake (out_valid high only in DONE)
//   diff     [WIDTH-1:0] out: a - b mod 2^WIDTH
//   borrow              out : 1 iff a < b unsigned
//   overflow            out : signed overflow
//   zero                out : diff == 0
// ----------------------------------------------------------------------------
module seq_sub32
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int MSB   = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Registered operands split into slices so the shared slice can be
    // muxed by the counter.
    logic [SLICE_W-1:0] a_sl [N];
    logic [SLICE_W-1:0] b_sl [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slices
            assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
            assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    logic [SLICE_W-1:0] sl_diff;
    logic               sl_bout;

    sub16 u_slice (
        .a    (a_sl[cnt_q]),
        .b    (b_sl[cnt_q]),
        .bin  (borrow_q),
        .diff (sl_diff),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = CALC;
                end
            end

            CALC: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        diff_d[i*SLICE_W +: SLICE_W] = sl_diff;
                    end
                end
                borrow_d = sl_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    // Flags are taken from the completed difference so they
                    // are registered together with the last slice.
                    ovf_d  = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
                    zero_d = (diff_d == '0);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Handshake outputs decode the state register only, so neither depends
    // combinationally on in_valid or out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule : seq_sub32

// File: doc/seq_sub32.md
# seq_sub32

Multi-cycle two's-complement subtractor computing `a - b`, 16 bits per clock, through one shared 16-bit ripple-borrow slice. It is the subtract counterpart to the team's combinational ripple adders and sits in the datapath where area matters more than latency. Operands enter and results leave over valid/ready handshakes. Each result carries borrow, signed-overflow and zero flags.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; must be a non-zero multiple of 16. The slice count is N = WIDTH/16.

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operands present.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, WIDTH: minuend.
- `b`, in, WIDTH: subtrahend.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `diff`, out, WIDTH: `a - b` mod 2^WIDTH.
- `borrow`, out, 1: unsigned borrow-out, 1 iff `a < b` unsigned.
- `overflow`, out, 1: signed overflow.
- `zero`, out, 1: `diff == 0`.

## Operation
- **FSM states:** IDLE, CALC, DONE. Reset puts the FSM in IDLE.
- **IDLE:** `in_ready=1`. On `in_valid && in_ready`:
  - capture `a` and `b` into internal registers;
  - clear the slice counter and the running borrow;
  - go to CALC.
- **CALC:** `in_ready=0`. Each cycle processes slice i = counter:
  - compute `a[16i+:16] - b[16i+:16] - borrow_reg`;
  - write the 16-bit result into `diff[16i+:16]`;
  - write the slice borrow-out into `borrow_reg`;
  - increment the counter.
  - After slice N-1, go to DONE.
- **DONE:**
  - `out_valid=1`.
  - `borrow` = final slice borrow-out.
  - `overflow = (a_reg[MSB] != b_reg[MSB]) && (diff[MSB] != a_reg[MSB])`.
  - `zero = (diff == 0)`.
  - On `out_ready`, return to IDLE.
- **Result hold:** `diff`, `borrow`, `overflow` and `zero` stay stable from the moment `out_valid` rises until the handshake completes.
- **Operand isolation:** changes on `a`, `b` or `in_valid` outside IDLE are ignored; the operands are the registered copies.
- **No overlap:** an operand accept never coincides with a result handoff. `in_ready` and `out_valid` are never both 1.
- **Reset values:** `in_ready` is 1 once IDLE is reached. `out_valid`, `diff`, `borrow`, `overflow` and `zero` are all 0.
- **Reset mid-operation:** `rst` in CALC or DONE aborts the operation; the next cycle is IDLE with all outputs at reset values. No `out_valid` pulse is produced for the aborted operation.
- **Reset precedence:** `rst` overrides any handshake sampled on the same edge.

## Timing
- **Accept:** at edge k.
- **CALC:** occupies cycles k+1 … k+N.
- **Result:** `out_valid` is high from cycle k+N+1; for WIDTH=32 this is 3 cycles after the accept edge.
- **Return to IDLE:** with `out_ready=1`, the block returns to IDLE one cycle after `out_valid` rises; `in_ready` is high the cycle after that.
- **Throughput:** minimum is one operation per N+2 cycles.
- **Flag timing:** flags and `diff` are registered, with no combinational path from inputs to outputs.
- **Combinational path:** `out_ready` → `in_ready` is not combinational.

## Structure
- **Shared package `seq_sub_pkg`:**
  - state enum {IDLE, CALC, DONE};
  - `SLICE_W = 16`;
  - the counter width function `$clog2(WIDTH/16)`, minimum 1.
- **Sub-module `sub16`:**
  - purely combinational: `a[15:0]`, `b[15:0]`, `bin` → `diff[15:0]`, `bout`;
  - a ripple of 1-bit full subtractors, with `diff = a^b^bin` and `bout = (~a&b) | (~(a^b)&bin)`;
  - instantiated once and muxed by slice index.

## Test plan
- **Inter-slice borrow:** `a=0x0001_0000`, `b=0x0000_0001` → `diff=0x0000_FFFF`, `borrow=0`, `overflow=0`, `zero=0`; `out_valid` 3 cycles after accept.
- **Unsigned underflow:** `a=0`, `b=1` → `diff=0xFFFF_FFFF`, `borrow=1`, `overflow=0`, `zero=0`.
- **Signed overflow:** `a=0x8000_0000`, `b=1` → `diff=0x7FFF_FFFF`, `overflow=1`, `borrow=0`.
  - Also `a=0x7FFF_FFFF`, `b=0xFFFF_FFFF` → `diff=0x8000_0000`, `overflow=1`, `borrow=1`.
- **Equal operands:** `a=b=0x1234_5678` → `diff=0`, `zero=1`, `borrow=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles while driving new `in_valid` with changing `a`/`b`.
  - Outputs stay stable and `in_ready` stays 0.
  - After `out_ready=1`, the new operands are accepted only once `in_ready` is 1, and they produce the correct result.
- **Reset mid-operation:** assert `rst` for 1 cycle during CALC (slice 0 done).
  - Next cycle: IDLE, `out_valid=0`, `diff=0`, all flags 0, `in_ready=1`.
  - No stale result appears afterwards; a following operation produces the correct result.
